// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word-fall-through output.
// Every sideband is stored next to its tdata beat so that packets leave exactly as they arrived.
module axis_sync_fifo #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 8,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int USER_W = 1,
    localparam int BW    = DATA_W / 8
) (
    input  logic              s_axis_clk,
    input  logic              s_axis_rst,

    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [BW-1:0]     s_axis_tstrb,
    input  logic [BW-1:0]     s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic [ID_W-1:0]   s_axis_tid,
    input  logic [DEST_W-1:0] s_axis_tdest,
    input  logic [USER_W-1:0] s_axis_tuser,

    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [BW-1:0]     m_axis_tstrb,
    output logic [BW-1:0]     m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [ID_W-1:0]   m_axis_tid,
    output logic [DEST_W-1:0] m_axis_tdest,
    output logic [USER_W-1:0] m_axis_tuser
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + 2 * BW + 1 + ID_W + DEST_W + USER_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Handshake flags depend only on the registered count, never on the inputs.
    assign s_axis_tready = (count != CNT_FULL);
    assign m_axis_tvalid = (count != '0);

    assign push = s_axis_tvalid & s_axis_tready;
    assign pop  = m_axis_tvalid & m_axis_tready;

    assign wr_entry = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                       s_axis_tid, s_axis_tdest, s_axis_tuser};

    always_ff @(posedge s_axis_clk) begin
        if (s_axis_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; a write during reset is suppressed so reset wins over push.
    always_ff @(posedge s_axis_clk) begin
        if (push && !s_axis_rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head_entry = mem[rd_ptr];

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = head_entry;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomized bench for axis_sync_fifo; a queue of beats models the FIFO contents.
// Each scenario task drives the DUT and compares its outputs against the queue.
module tb_axis_sync_fifo;

    localparam int DEPTH  = 1024;
    localparam int DATA_W = 8;
    localparam int BW     = DATA_W / 8;
    localparam int ID_W   = 1;
    localparam int DEST_W = 1;
    localparam int USER_W = 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [BW-1:0]     strb;
        logic [BW-1:0]     keep;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
    } beat_t;

    logic              clk = 1'b0;
    logic              s_axis_rst;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [BW-1:0]     m_axis_tstrb;
    logic [BW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
    logic [ID_W-1:0]   m_axis_tid;
    logic [DEST_W-1:0] m_axis_tdest;
    logic [USER_W-1:0] m_axis_tuser;

    beat_t in_beat;
    beat_t q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    axis_sync_fifo #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W), .DEST_W(DEST_W), .USER_W(USER_W)
    ) dut (
        .s_axis_clk    (clk),
        .s_axis_rst    (s_axis_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (in_beat.data),
        .s_axis_tstrb  (in_beat.strb),
        .s_axis_tkeep  (in_beat.keep),
        .s_axis_tlast  (in_beat.last),
        .s_axis_tid    (in_beat.id),
        .s_axis_tdest  (in_beat.dest),
        .s_axis_tuser  (in_beat.user),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser)
    );

    function automatic beat_t out_beat();
        return {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
                m_axis_tid, m_axis_tdest, m_axis_tuser};
    endfunction

    function automatic beat_t rand_beat();
        logic [31:0] r;
        r = $urandom;
        return r[$bits(beat_t)-1:0];
    endfunction

    // One clock: the model takes a beat when it has room and gives one when it holds any.
    task automatic cycle();
        bit do_push;
        bit do_pop;
        do_push = s_axis_tvalid && (q.size() < DEPTH);
        do_pop  = m_axis_tready && (q.size() > 0);
        @(posedge clk);
        if (s_axis_rst) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_beat);
        end
        #1;
    endtask

    task automatic test_reset();
        s_axis_rst = 1'b1;
        cycle();
        cycle();
        s_axis_rst = 1'b0;
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_tready: got %b expected 1", s_axis_tready);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_fill();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_beat      = rand_beat();
            in_beat.data = DATA_W'(i % 256);
            n_checks++;
            if (s_axis_tready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL fill_tready beat %0d: got %b expected 1", i, s_axis_tready);
            end
            cycle();
        end
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_tready: got %b expected 0", s_axis_tready);
        end
        // Offer one more beat and hold it; it must not be taken.
        in_beat      = rand_beat();
        in_beat.data = 8'hAA;
        repeat (5) begin
            cycle();
            n_checks++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL full_hold: got tready=%b tvalid=%b tdata=%h expected 0 1 00",
                         s_axis_tready, m_axis_tvalid, m_axis_tdata);
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_drain();
        int seen;
        seen          = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < DEPTH + 16 && m_axis_tvalid === 1'b1; c++) begin
            n_checks++;
            if (m_axis_tdata !== DATA_W'(seen % 256) || q.size() == 0 || out_beat() !== q[0]) begin
                n_fail++;
                $display("[TB] FAIL drain_beat %0d: got %h expected data %h", seen, out_beat(),
                         DATA_W'(seen % 256));
            end
            seen++;
            cycle();
        end
        n_checks++;
        if (seen != DEPTH) begin
            n_fail++;
            $display("[TB] FAIL drain_count: got %0d expected %0d", seen, DEPTH);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_empty: got tvalid=%b tready=%b expected 0 1",
                     m_axis_tvalid, s_axis_tready);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_full_pop();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_beat = rand_beat();
            cycle();
        end
        in_beat = rand_beat();
        cycle();
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fullpop_full: got %b expected 0", s_axis_tready);
        end
        // Pop while full with the producer still holding its beat.
        m_axis_tready = 1'b1;
        cycle();
        n_checks++;
        if (s_axis_tready !== 1'b1 || out_beat() !== q[0]) begin
            n_fail++;
            $display("[TB] FAIL fullpop_reassert: got tready=%b head=%h expected 1 %h",
                     s_axis_tready, out_beat(), q[0]);
        end
        m_axis_tready = 1'b0;
        cycle();
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fullpop_refill: got %b expected 0", s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            in_beat       = rand_beat();
            s_axis_tvalid = ($urandom % 4) != 0;
            m_axis_tready = ($urandom % 4) != 0;
            cycle();
            n_checks++;
            if (s_axis_tready !== (q.size() != DEPTH) || m_axis_tvalid !== (q.size() != 0) ||
                (q.size() != 0 && out_beat() !== q[0])) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got tready=%b tvalid=%b head=%h level %0d",
                         c, s_axis_tready, m_axis_tvalid, out_beat(), q.size());
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_streaming();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < DEPTH + 16 && q.size() != 0; c++) begin
            n_checks++;
            if (out_beat() !== q[0]) begin
                n_fail++;
                $display("[TB] FAIL stream_predrain: got %h expected %h", out_beat(), q[0]);
            end
            cycle();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stream_empty: got %b expected 0", m_axis_tvalid);
        end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (5) begin
            in_beat = rand_beat();
            cycle();
        end
        // Continuous push and pop at a level of five; pointers wrap several times.
        m_axis_tready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            in_beat = rand_beat();
            cycle();
            n_checks++;
            if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b1 || q.size() != 5 ||
                out_beat() !== q[0]) begin
                n_fail++;
                $display("[TB] FAIL stream beat %0d: got tready=%b tvalid=%b head=%h expected 1 1 %h",
                         c, s_axis_tready, m_axis_tvalid, out_beat(), q[0]);
            end
        end
        s_axis_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || out_beat() !== q[0]) begin
                n_fail++;
                $display("[TB] FAIL stream_tail %0d: got %h expected %h", c, out_beat(), q[0]);
            end
            cycle();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stream_done: got %b expected 0", m_axis_tvalid);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_sidebands();
        beat_t exp;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_beat      = '0;
            in_beat.data = DATA_W'(8'h40 + i);
            if (i % 3 == 0) begin
                in_beat.strb = '1;
                in_beat.keep = '1;
                in_beat.last = 1'b1;
                in_beat.id   = '1;
                in_beat.dest = '1;
                in_beat.user = '1;
            end
            cycle();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            exp      = '0;
            exp.data = DATA_W'(8'h40 + j);
            if (j % 3 == 0) begin
                exp.strb = '1;
                exp.keep = '1;
                exp.last = 1'b1;
                exp.id   = '1;
                exp.dest = '1;
                exp.user = '1;
            end
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || out_beat() !== exp) begin
                n_fail++;
                $display("[TB] FAIL sideband beat %0d: got %h expected %h", j, out_beat(), exp);
            end
            cycle();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sideband_empty: got %b expected 0", m_axis_tvalid);
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_mid_reset();
        beat_t first;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        repeat (10) begin
            in_beat = rand_beat();
            cycle();
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_loaded: got %b expected 1", m_axis_tvalid);
        end
        // Push and pop requested in the same cycle as reset; reset must win.
        s_axis_rst    = 1'b1;
        m_axis_tready = 1'b1;
        in_beat       = rand_beat();
        cycle();
        s_axis_rst    = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_cleared: got tvalid=%b tready=%b expected 0 1",
                     m_axis_tvalid, s_axis_tready);
        end
        m_axis_tready = 1'b0;
        first         = rand_beat();
        first.data    = 8'h5A;
        in_beat       = first;
        cycle();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || out_beat() !== first) begin
            n_fail++;
            $display("[TB] FAIL midrst_first: got tvalid=%b head=%h expected 1 %h",
                     m_axis_tvalid, out_beat(), first);
        end
        m_axis_tready = 1'b1;
        cycle();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midrst_single: got %b expected 0", m_axis_tvalid);
        end
        m_axis_tready = 1'b0;
    endtask

    initial begin
        s_axis_rst    = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        in_beat       = '0;
        test_reset();
        test_fill();
        test_drain();
        test_full_pop();
        test_random();
        test_streaming();
        test_sidebands();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
